seg_scan_reader: RTL and testbench

Receive-side companion to the stopwatch's BCD-to-7-segment decode path. It samples a time-multiplexed 4-digit, active-low 7-segment bus (segment lines plus one-hot digit strobes) and reconstructs the four BCD digits being shown. Each digit pattern is debounced, and each completed frame is presented on a valid/ready output. It sits in the self-check path of the stopwatch display, or at the input of a bench, and watches the scanned display output.

---
 rtl/seg_scan_reader.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_reader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_reader.sv
// Recovers four BCD digits from a scanned, active-low 7-segment bus.
// Each digit is debounced before capture; completed frames leave on a valid/ready port.
module seg_scan_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  dig_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_bcd,
  output logic [3:0]  out_err,
  output logic        overflow
);

  typedef enum logic [1:0] {SEEK, SETTLE, HOLD} state_t;

  logic [6:0] seg_m_q, s_seg;
  logic [3:0] sel_m_q, s_sel;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      ref_sel_q, ref_sel_d;
  logic [6:0]      ref_seg_q, ref_seg_d;
  logic [3:0][3:0] slot_bcd_q, slot_bcd_d;
  logic [3:0]      slot_err_q, slot_err_d;
  logic [3:0]      seen_q, seen_d;
  logic            out_valid_q, out_valid_d;
  logic [3:0][3:0] out_bcd_q, out_bcd_d;
  logic [3:0]      out_err_q, out_err_d;
  logic            overflow_q, overflow_d;

  logic [8:0] cnt_inc;
  logic [4:0] dec;
  logic [1:0] ref_idx;
  logic       frame_done, load;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] sel_idx(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // {err, bcd}; blank decodes to F without flagging an error
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40: return 5'h00;
      7'h79: return 5'h01;
      7'h24: return 5'h02;
      7'h30: return 5'h03;
      7'h19: return 5'h04;
      7'h12: return 5'h05;
      7'h02: return 5'h06;
      7'h78: return 5'h07;
      7'h00: return 5'h08;
      7'h10: return 5'h09;
      7'h7F: return 5'h0F;
      default: return 5'h1F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m_q <= 7'h7F;
      s_seg   <= 7'h7F;
      sel_m_q <= 4'd0;
      s_sel   <= 4'd0;
    end else begin
      seg_m_q <= seg_n;
      s_seg   <= seg_m_q;
      sel_m_q <= dig_sel;
      s_sel   <= sel_m_q;
    end
  end

  assign cnt_inc    = {1'b0, cnt_q} + 9'd1;
  assign dec        = decode(ref_seg_q);
  assign ref_idx    = sel_idx(ref_sel_q);
  assign frame_done = (seen_q == 4'hF);
  assign load       = frame_done && (!out_valid_q || out_ready);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ref_sel_d  = ref_sel_q;
    ref_seg_d  = ref_seg_q;
    slot_bcd_d = slot_bcd_q;
    slot_err_d = slot_err_q;
    seen_d     = frame_done ? 4'd0 : seen_q;
    case (state_q)
      SEEK: if (is_onehot(s_sel)) begin
        state_d   = SETTLE;
        cnt_d     = 8'd1;
        ref_sel_d = s_sel;
        ref_seg_d = s_seg;
      end
      SETTLE: begin
        if (s_sel == ref_sel_q && s_seg == ref_seg_q) begin
          cnt_d = cnt_inc[8] ? 8'hFF : cnt_inc[7:0];
          // this sample is the STABLE_CYCLES-th identical one in a row
          if (cnt_inc >= 9'(STABLE_CYCLES)) begin
            slot_bcd_d[ref_idx] = dec[3:0];
            slot_err_d[ref_idx] = dec[4];
            seen_d[ref_idx]     = 1'b1;
            state_d             = HOLD;
          end
        end else if (is_onehot(s_sel)) begin
          cnt_d     = 8'd1;
          ref_sel_d = s_sel;
          ref_seg_d = s_seg;
        end else begin
          state_d = SEEK;
        end
      end
      HOLD: if (s_sel != ref_sel_q) state_d = SEEK;
      default: state_d = SEEK;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_err_d   = out_err_q;
    overflow_d  = overflow_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_bcd_d   = slot_bcd_q;
      out_err_d   = slot_err_q;
    end else if (frame_done) begin
      overflow_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEEK;
      cnt_q       <= 8'd0;
      ref_sel_q   <= 4'd0;
      ref_seg_q   <= 7'h7F;
      slot_bcd_q  <= 16'hFFFF;
      slot_err_q  <= 4'd0;
      seen_q      <= 4'd0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= 16'hFFFF;
      out_err_q   <= 4'd0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_sel_q   <= ref_sel_d;
      ref_seg_q   <= ref_seg_d;
      slot_bcd_q  <= slot_bcd_d;
      slot_err_q  <= slot_err_d;
      seen_q      <= seen_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_err_q   <= out_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_err   = out_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: scanned frames, glitches, bad patterns,
// backpressure, illegal strobes and mid-frame reset.
module tb_seg_scan_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_sel;
  logic        out_valid, out_ready, overflow;
  logic [15:0] out_bcd;
  logic [3:0]  out_err;

  int checks = 0, failures = 0;
  int hs_cnt = 0, hs0;
  logic [15:0] hs_bcd = 16'h0;
  logic [3:0]  hs_err = 4'h0;

  seg_scan_reader #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_sel(dig_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_err(out_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      hs_cnt = hs_cnt + 1;
      hs_bcd = out_bcd;
      hs_err = out_err;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic show(input int k, input logic [6:0] pat, input int n);
    logic [3:0] one;
    one     = 4'b0001;
    dig_sel = one << k;
    seg_n   = pat;
    tick(n);
  endtask

  task automatic idle(input int n);
    dig_sel = 4'd0;
    seg_n   = 7'h7F;
    tick(n);
  endtask

  task automatic scan4(input logic [6:0] p3, p2, p1, p0);
    show(3, p3, 8);
    show(2, p2, 8);
    show(1, p1, 8);
    show(0, p0, 8);
    idle(8);
  endtask

  initial begin
    rst_n = 1'b0; seg_n = 7'h7F; dig_sel = 4'd0; out_ready = 1'b1;
    tick(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(out_bcd), 32'hFFFF);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // frame 1234
    scan4(7'h79, 7'h24, 7'h30, 7'h19);
    chk("f1_hs", 32'(hs_cnt), 32'd1);
    chk("f1_bcd", 32'(hs_bcd), 32'h1234);
    chk("f1_err", 32'(hs_err), 32'd0);
    chk("f1_valid_drop", 32'(out_valid), 32'd0);

    // 5, bad pattern, blank, then a 3-sample glitch of 0 before a stable 1
    show(3, 7'h12, 8);
    show(2, 7'h55, 8);
    show(1, 7'h7F, 8);
    idle(2);
    show(0, 7'h40, 3);
    show(0, 7'h79, 10);
    idle(8);
    chk("f2_hs", 32'(hs_cnt), 32'd2);
    chk("f2_bcd", 32'(hs_bcd), 32'h5FF1);
    chk("f2_err", 32'(hs_err), 32'h4);
    chk("f2_glitch_slot0", 32'(hs_bcd[3:0]), 32'h1);

    // backpressure across two frames
    out_ready = 1'b0;
    scan4(7'h79, 7'h24, 7'h30, 7'h19);
    chk("bp1_valid", 32'(out_valid), 32'd1);
    chk("bp1_bcd", 32'(out_bcd), 32'h1234);
    chk("bp1_ovf", 32'(overflow), 32'd0);
    scan4(7'h12, 7'h02, 7'h78, 7'h00);
    chk("bp2_valid", 32'(out_valid), 32'd1);
    chk("bp2_bcd_held", 32'(out_bcd), 32'h1234);
    chk("bp2_ovf", 32'(overflow), 32'd1);
    hs0 = hs_cnt;
    out_ready = 1'b1;
    tick(4);
    chk("bp_one_hs", 32'(hs_cnt - hs0), 32'd1);
    chk("bp_hs_bcd", 32'(hs_bcd), 32'h1234);
    chk("bp_valid_drop", 32'(out_valid), 32'd0);

    // illegal strobes must not capture slot 0 or 1
    hs0 = hs_cnt;
    dig_sel = 4'b0011; seg_n = 7'h79; tick(20);
    dig_sel = 4'b0000; tick(20);
    show(3, 7'h78, 8);
    show(2, 7'h02, 8);
    show(1, 7'h12, 8);
    idle(8);
    chk("ill_no_hs", 32'(hs_cnt - hs0), 32'd0);
    chk("ill_valid", 32'(out_valid), 32'd0);
    show(0, 7'h19, 8);
    idle(8);
    chk("ill_done_hs", 32'(hs_cnt - hs0), 32'd1);
    chk("ill_done_bcd", 32'(hs_bcd), 32'h7654);
    chk("ill_done_ovf", 32'(overflow), 32'd1);

    // asynchronous reset in the middle of a scan with a frame pending
    out_ready = 1'b0;
    scan4(7'h19, 7'h30, 7'h24, 7'h79);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    show(3, 7'h40, 8);
    show(2, 7'h40, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_bcd", 32'(out_bcd), 32'hFFFF);
    chk("mid_rst_err", 32'(out_err), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    tick(2);
    dig_sel = 4'd0; seg_n = 7'h7F;
    rst_n = 1'b1;
    tick(10);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    hs0 = hs_cnt;
    show(1, 7'h00, 8);
    show(0, 7'h78, 8);
    idle(10);
    chk("partial_discard_hs", 32'(hs_cnt - hs0), 32'd0);
    scan4(7'h10, 7'h40, 7'h00, 7'h78);
    chk("post_rst_hs", 32'(hs_cnt - hs0), 32'd1);
    chk("post_rst_bcd", 32'(hs_bcd), 32'h9087);
    chk("post_rst_err", 32'(hs_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
